// File: rtl/cnt_arb.sv
`default_nettype none
// ============================================================================
// Module   : cnt_arb
// Brief    : Round-robin arbiter sharing one interval counter among N clients;
//            the winner's interval is latched, counted, then a done pulse.
// Revision : 1.0
// ============================================================================
module cnt_arb #(
   parameter int WIDTH = 32,
   parameter int N     = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       req,
   input  logic [N*WIDTH-1:0] top,
   output logic [N-1:0]       gnt,
   output logic [N-1:0]       done,
   output logic               busy,
   output logic [WIDTH-1:0]   cnt
);

   localparam int IW = $clog2(N);

   localparam logic [1:0]   c_IDLE    = 2'd0;
   localparam logic [1:0]   c_RUN     = 2'd1;
   localparam logic [1:0]   c_DONE    = 2'd2;
   localparam logic [N-1:0] c_ONEHOT0 = {{(N-1){1'b0}}, 1'b1};

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [IW-1:0]    r_last;
   logic [WIDTH-1:0] r_tl;

   logic [IW-1:0]    w_idx;
   logic [IW-1:0]    w_win;
   logic             w_win_vld;
   logic [N-1:0]     w_win_oh;
   logic [WIDTH-1:0] w_tl_win;
   logic             w_abort;
   logic             w_last_cnt;

   logic [N-1:0]     w_gnt_nxt;
   logic [N-1:0]     w_done_nxt;
   logic             w_busy_nxt;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic [IW-1:0]    w_last_nxt;
   logic [WIDTH-1:0] w_tl_nxt;

   logic [WIDTH-1:0] w_top [N];

   generate
      for (genvar k = 0; k < N; k++) begin : g_top
         assign w_top[k] = top[k*WIDTH +: WIDTH];
      end
   endgenerate

   // Rotating priority: search starts just after the previous winner.
   always_comb begin
      w_idx     = '0;
      w_win     = '0;
      w_win_vld = 1'b0;
      for (int i = 1; i <= N; i++) begin
         w_idx = IW'((int'(r_last) + i) % N);
         if (!w_win_vld && req[w_idx]) begin
            w_win_vld = 1'b1;
            w_win     = w_idx;
         end
      end
   end

   assign w_win_oh   = c_ONEHOT0 << w_win;
   assign w_tl_win   = (w_top[w_win] == '0) ? WIDTH'(1) : w_top[w_win];
   assign w_abort    = !req[r_last];
   assign w_last_cnt = (cnt == r_tl - WIDTH'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (w_win_vld) w_state_nxt = c_RUN;
         c_RUN: begin
            if (w_abort)         w_state_nxt = c_IDLE;
            else if (w_last_cnt) w_state_nxt = c_DONE;
         end
         c_DONE:  w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // Next values of the registered outputs; abort takes priority over completion.
   always_comb begin
      w_gnt_nxt  = gnt;
      w_done_nxt = done;
      w_busy_nxt = busy;
      w_cnt_nxt  = cnt;
      w_last_nxt = r_last;
      w_tl_nxt   = r_tl;
      case (r_state)
         c_IDLE: begin
            if (w_win_vld) begin
               w_gnt_nxt  = w_win_oh;
               w_done_nxt = '0;
               w_busy_nxt = 1'b1;
               w_cnt_nxt  = '0;
               w_last_nxt = w_win;
               w_tl_nxt   = w_tl_win;
            end
         end
         c_RUN: begin
            if (w_abort) begin
               w_gnt_nxt  = '0;
               w_busy_nxt = 1'b0;
               w_cnt_nxt  = '0;
            end else if (w_last_cnt) begin
               w_gnt_nxt  = '0;
               w_done_nxt = gnt;
               w_cnt_nxt  = '0;
            end else begin
               w_cnt_nxt  = cnt + WIDTH'(1);
            end
         end
         c_DONE: begin
            w_done_nxt = '0;
            w_busy_nxt = 1'b0;
         end
         default: begin
            w_gnt_nxt  = '0;
            w_done_nxt = '0;
            w_busy_nxt = 1'b0;
            w_cnt_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt    <= '0;
         done   <= '0;
         busy   <= 1'b0;
         cnt    <= '0;
         r_last <= IW'(N - 1);
         r_tl   <= WIDTH'(1);
      end else begin
         gnt    <= w_gnt_nxt;
         done   <= w_done_nxt;
         busy   <= w_busy_nxt;
         cnt    <= w_cnt_nxt;
         r_last <= w_last_nxt;
         r_tl   <= w_tl_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cnt_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnt_arb
// Brief    : Directed scoreboard bench for cnt_arb (WIDTH=8, N=4).
// Revision : 1.0
// ============================================================================
module tb_cnt_arb;

   localparam int WIDTH = 8;
   localparam int N     = 4;

   typedef struct packed {
      logic [N-1:0]     gnt;
      logic [N-1:0]     done;
      logic             busy;
      logic [WIDTH-1:0] cnt;
   } exp_t;

   logic               clk;
   logic               rst;
   logic [N-1:0]       req;
   logic [N*WIDTH-1:0] top;
   logic [N-1:0]       gnt;
   logic [N-1:0]       done;
   logic               busy;
   logic [WIDTH-1:0]   cnt;

   int   checks;
   int   errors;
   exp_t sb[$];

   cnt_arb #(.WIDTH(WIDTH), .N(N)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .top  (top),
      .gnt  (gnt),
      .done (done),
      .busy (busy),
      .cnt  (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [N-1:0] g, input logic [N-1:0] d,
                               input logic b, input logic [WIDTH-1:0] c);
      exp_t e;
      e.gnt  = g;
      e.done = d;
      e.busy = b;
      e.cnt  = c;
      return e;
   endfunction

   task automatic check_now(input string tag);
      exp_t e;
      exp_t obs;
      obs.gnt  = gnt;
      obs.done = done;
      obs.busy = busy;
      obs.cnt  = cnt;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL %s scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s got gnt=%b done=%b busy=%b cnt=%0d exp gnt=%b done=%b busy=%b cnt=%0d",
                   tag, obs.gnt, obs.done, obs.busy, obs.cnt, e.gnt, e.done, e.busy, e.cnt);
         end
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      #1;
      check_now(tag);
   endtask

   task automatic set_top(input int k, input logic [WIDTH-1:0] v);
      top[k*WIDTH +: WIDTH] = v;
   endtask

   // One full service: tl grant cycles counting 0..tl-1, one done cycle, one idle cycle.
   task automatic serve(input int k, input int tl, input string tag);
      logic [N-1:0] one;
      logic [N-1:0] oh;
      one = 4'b0001;
      oh  = one << k;
      for (int i = 0; i < tl; i++) begin
         sb.push_back(mk(oh, '0, 1'b1, WIDTH'(i)));
         step(tag);
      end
      sb.push_back(mk('0, oh, 1'b1, '0));
      step(tag);
      sb.push_back(mk('0, '0, 1'b0, '0));
      step(tag);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      #1;
      sb.push_back(mk('0, '0, 1'b0, '0));
      check_now("rst_pulse");
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      req    = '0;
      top    = '0;

      @(posedge clk);
      #1;
      sb.push_back(mk('0, '0, 1'b0, '0));
      check_now("reset_state");
      rst = 1'b0;

      // Single requester, interval 4
      set_top(0, 8'd4);
      req = 4'b0001;
      serve(0, 4, "t1_single");
      req = 4'b0000;

      // All requesting: rotation 0,1,2,3,0 from a fresh reset
      reset_dut();
      for (int k = 0; k < N; k++) set_top(k, 8'd2);
      req = 4'b1111;
      serve(0, 2, "t2_rr0");
      serve(1, 2, "t2_rr1");
      serve(2, 2, "t2_rr2");
      serve(3, 2, "t2_rr3");
      serve(0, 2, "t2_rr0b");
      req = 4'b0000;

      // top=0 behaves as top=1
      set_top(0, 8'd0);
      req = 4'b0001;
      serve(0, 1, "t3_top0");
      set_top(0, 8'd1);
      serve(0, 1, "t3_top1");
      req = 4'b0000;

      // Abort mid-run: no done pulse
      set_top(0, 8'd10);
      req = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         sb.push_back(mk(4'b0001, '0, 1'b1, WIDTH'(i)));
         step("t4_run");
      end
      req = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         sb.push_back(mk('0, '0, 1'b0, '0));
         step("t4_abort");
      end

      // Asynchronous reset mid-run, then pointer restart
      set_top(2, 8'd8);
      req = 4'b0100;
      for (int i = 0; i < 4; i++) begin
         sb.push_back(mk(4'b0100, '0, 1'b1, WIDTH'(i)));
         step("t5_run");
      end
      rst = 1'b1;
      #1;
      sb.push_back(mk('0, '0, 1'b0, '0));
      check_now("t5_async_rst");
      sb.push_back(mk('0, '0, 1'b0, '0));
      step("t5_rst_held");
      rst = 1'b0;
      set_top(0, 8'd3);
      req = 4'b0101;
      serve(0, 3, "t5_after_rst");
      req = 4'b0000;

      // Interval latched at grant; later top changes ignored
      set_top(1, 8'd5);
      req = 4'b0010;
      for (int i = 0; i < 2; i++) begin
         sb.push_back(mk(4'b0010, '0, 1'b1, WIDTH'(i)));
         step("t6_run");
      end
      set_top(1, 8'd2);
      for (int i = 2; i < 5; i++) begin
         sb.push_back(mk(4'b0010, '0, 1'b1, WIDTH'(i)));
         step("t6_run_late");
      end
      sb.push_back(mk('0, 4'b0010, 1'b1, '0));
      step("t6_done");
      req = 4'b0000;
      sb.push_back(mk('0, '0, 1'b0, '0));
      step("t6_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
